// File: rtl/mem_test_pkg.sv
// Shared encodings for the MIG memory tester: FSM states, MIG command codes, pattern modes, LFSR taps.
package mem_test_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_ISSUE = 3'd1,
        ST_WR_WAIT  = 3'd2,
        ST_RD_ISSUE = 3'd3,
        ST_RD_DRAIN = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    localparam logic [1:0] MODE_FIXED = 2'd0;
    localparam logic [1:0] MODE_ADDR  = 2'd1;
    localparam logic [1:0] MODE_ALT   = 2'd2;
    localparam logic [1:0] MODE_LFSR  = 2'd3;

    // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1.
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/mem_test_patgen.sv
// Combinational beat pattern generator, shared by the write path and the read-check path.
// With MEM_TEST_LFSR_EN defined, mode 3 uses the LFSR state input; otherwise mode 3 falls back to PATTERN.
module mem_test_patgen
    import mem_test_pkg::*;
#(
    parameter int                DATA_W  = 256,
    parameter int                ADDR_W  = 29,
    parameter logic [DATA_W-1:0] PATTERN = '0
) (
    input  logic [1:0]        mode,
    input  logic              beat_odd,
    input  logic [ADDR_W-1:0] addr,
`ifdef MEM_TEST_LFSR_EN
    input  logic [31:0]       lfsr,
`endif
    output logic [DATA_W-1:0] data
);

    localparam int WORDS = DATA_W / 32;

    logic [31:0] addr32;
    assign addr32 = 32'(addr);

    always_comb begin
        data = PATTERN;
        case (mode)
            MODE_ADDR: begin
                for (int k = 0; k < WORDS; k++) begin
                    data[k*32 +: 32] = addr32 ^ 32'(k);
                end
            end
            MODE_ALT: data = beat_odd ? ~PATTERN : PATTERN;
`ifdef MEM_TEST_LFSR_EN
            MODE_LFSR: begin
                for (int k = 0; k < WORDS; k++) begin
                    data[k*32 +: 32] = lfsr ^ 32'(k);
                end
            end
`endif
            default: data = PATTERN;
        endcase
    end

endmodule

// File: rtl/mig_mem_tester.sv
// MIG app-interface tester: writes NUM_BEATS pattern beats (one at a time), reads them back-to-back and scores in-order responses.
// Optional MEM_TEST_LFSR_EN enables the LFSR pattern in mode 3; a calib_done drop while busy aborts to DONE.
module mig_mem_tester
    import mem_test_pkg::*;
#(
    parameter int                DATA_W    = 256,
    parameter int                ADDR_W    = 29,
    parameter int                NUM_BEATS = 16,
    parameter int                ADDR_STEP = 8,
    parameter logic [DATA_W-1:0] PATTERN   = {32'hcafebabe, 32'h12345678, 32'hAA55AA55, 32'h55AA55AA,
                                              32'hdeadbeef, 32'h87654321, 32'h55AA55AA, 32'hAA55AA55},
    parameter logic [31:0]       SEED      = 32'h0000_0001
) (
    input  logic                  ui_clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic                  calib_done,
    output logic [ADDR_W-1:0]     app_addr,
    output logic [2:0]            app_cmd,
    output logic                  app_en,
    output logic [DATA_W-1:0]     app_wdf_data,
    output logic                  app_wdf_wren,
    output logic                  app_wdf_end,
    output logic [DATA_W/8-1:0]   app_wdf_mask,
    input  logic                  app_rdy,
    input  logic                  app_wdf_rdy,
    input  logic [DATA_W-1:0]     app_rd_data,
    input  logic                  app_rd_data_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  aborted,
    output logic [15:0]           err_cnt,
    output logic [ADDR_W-1:0]     first_err_addr
);

    if (SEED == 32'd0 || (DATA_W % 32) != 0) begin : g_bad_cfg
        $error("mig_mem_tester: SEED must be nonzero and DATA_W a multiple of 32");
    end

    localparam logic [15:0]       BEAT_LAST = 16'(NUM_BEATS - 1);
    localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(ADDR_STEP);

    state_t              state, state_nxt;
    logic [1:0]          mode_q;
    logic [ADDR_W-1:0]   base_q;
    logic [ADDR_W-1:0]   beat_addr;
    logic [15:0]         beat_idx;
    logic [ADDR_W-1:0]   rsp_addr;
    logic [15:0]         rsp_idx;
    logic [DATA_W-1:0]   wr_pat;
    logic [DATA_W-1:0]   exp_pat;
`ifdef MEM_TEST_LFSR_EN
    logic [31:0]         lfsr_wr;
    logic [31:0]         lfsr_rd;
`endif

    logic start_acc, abort, wr_load, wr_beat_done, rd_start, rd_acc;
    logic rsp_take, rsp_last, rsp_err, beat_last;

    assign app_wdf_end  = app_wdf_wren;
    assign app_wdf_mask = '0;
    assign beat_last    = (beat_idx == BEAT_LAST);
    assign rsp_err      = rsp_take && (app_rd_data != exp_pat);

    mem_test_patgen #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PATTERN(PATTERN)) u_wr_pat (
        .mode     (mode_q),
        .beat_odd (beat_idx[0]),
        .addr     (beat_addr),
`ifdef MEM_TEST_LFSR_EN
        .lfsr     (lfsr_wr),
`endif
        .data     (wr_pat)
    );

    mem_test_patgen #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PATTERN(PATTERN)) u_exp_pat (
        .mode     (mode_q),
        .beat_odd (rsp_idx[0]),
        .addr     (rsp_addr),
`ifdef MEM_TEST_LFSR_EN
        .lfsr     (lfsr_rd),
`endif
        .data     (exp_pat)
    );

    always_ff @(posedge ui_clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = ST_DONE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: if (start_acc) state_nxt = ST_WR_ISSUE;
                ST_WR_ISSUE:      state_nxt = ST_WR_WAIT;
                ST_WR_WAIT:       if (wr_beat_done) state_nxt = beat_last ? ST_RD_ISSUE : ST_WR_ISSUE;
                ST_RD_ISSUE: begin
                    if (rsp_last)                   state_nxt = ST_DONE;
                    else if (rd_acc && beat_last)   state_nxt = ST_RD_DRAIN;
                end
                ST_RD_DRAIN:      if (rsp_last) state_nxt = ST_DONE;
                default:          state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy         = (state != ST_IDLE) && (state != ST_DONE);
        abort        = busy && !calib_done;
        start_acc    = ((state == ST_IDLE) || (state == ST_DONE)) && start && calib_done;
        wr_load      = (state == ST_WR_ISSUE) && !abort;
        // A write beat completes once neither the command nor the data strobe is still waiting.
        wr_beat_done = (state == ST_WR_WAIT) && !abort
                       && (!app_en || app_rdy) && (!app_wdf_wren || app_wdf_rdy);
        rd_start     = wr_beat_done && beat_last;
        rd_acc       = (state == ST_RD_ISSUE) && !abort && app_en && app_rdy;
        rsp_take     = ((state == ST_RD_ISSUE) || (state == ST_RD_DRAIN)) && !abort && app_rd_data_valid;
        rsp_last     = rsp_take && (rsp_idx == BEAT_LAST);
    end

    always_ff @(posedge ui_clk or posedge rst) begin
        if (rst) begin
            app_en         <= 1'b0;
            app_wdf_wren   <= 1'b0;
            app_addr       <= '0;
            app_cmd        <= CMD_WRITE;
            done           <= 1'b0;
            pass           <= 1'b0;
            aborted        <= 1'b0;
            err_cnt        <= 16'd0;
            first_err_addr <= '0;
            mode_q         <= MODE_FIXED;
            base_q         <= '0;
            beat_addr      <= '0;
            beat_idx       <= 16'd0;
            rsp_addr       <= '0;
            rsp_idx        <= 16'd0;
`ifdef MEM_TEST_LFSR_EN
            lfsr_wr        <= SEED;
            lfsr_rd        <= SEED;
`endif
        end else if (abort) begin
            app_en       <= 1'b0;
            app_wdf_wren <= 1'b0;
            done         <= 1'b1;
            pass         <= 1'b0;
            aborted      <= 1'b1;
        end else begin
            if (start_acc) begin
                mode_q         <= mode;
                base_q         <= base_addr;
                beat_addr      <= base_addr;
                rsp_addr       <= base_addr;
                beat_idx       <= 16'd0;
                rsp_idx        <= 16'd0;
                done           <= 1'b0;
                pass           <= 1'b0;
                aborted        <= 1'b0;
                err_cnt        <= 16'd0;
                first_err_addr <= '0;
`ifdef MEM_TEST_LFSR_EN
                lfsr_wr        <= SEED;
                lfsr_rd        <= SEED;
`endif
            end
            if (wr_load) begin
                app_en       <= 1'b1;
                app_wdf_wren <= 1'b1;
                app_cmd      <= CMD_WRITE;
                app_addr     <= beat_addr;
            end
            if (state == ST_WR_WAIT) begin
                if (app_en && app_rdy)             app_en       <= 1'b0;
                if (app_wdf_wren && app_wdf_rdy)   app_wdf_wren <= 1'b0;
            end
            if (wr_beat_done) begin
                beat_idx  <= beat_idx + 16'd1;
                beat_addr <= beat_addr + STEP;
`ifdef MEM_TEST_LFSR_EN
                lfsr_wr   <= lfsr_step(lfsr_wr);
`endif
            end
            if (rd_start) begin
                app_en   <= 1'b1;
                app_cmd  <= CMD_READ;
                app_addr <= base_q;
                beat_idx <= 16'd0;
            end
            if (rd_acc) begin
                if (beat_last) begin
                    app_en <= 1'b0;
                end else begin
                    app_addr <= app_addr + STEP;
                    beat_idx <= beat_idx + 16'd1;
                end
            end
            if (rsp_take) begin
                rsp_idx  <= rsp_idx + 16'd1;
                rsp_addr <= rsp_addr + STEP;
`ifdef MEM_TEST_LFSR_EN
                lfsr_rd  <= lfsr_step(lfsr_rd);
`endif
                if (rsp_err) begin
                    if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
                    if (err_cnt == 16'd0)    first_err_addr <= rsp_addr;
                end
            end
            if (rsp_last) begin
                app_en <= 1'b0;
                done   <= 1'b1;
                pass   <= (err_cnt == 16'd0) && !rsp_err;
            end
        end
    end

    always_ff @(posedge ui_clk) begin
        if (wr_load) app_wdf_data <= wr_pat;
    end

endmodule

// File: tb/tb_mig_mem_tester.sv
// Directed bench for mig_mem_tester (NUM_BEATS=4) against a small MIG memory model with programmable ready/latency.
module tb_mig_mem_tester;

    localparam int DW = 256;
    localparam int AW = 29;
    localparam logic [DW-1:0] PAT = {32'hcafebabe, 32'h12345678, 32'hAA55AA55, 32'h55AA55AA,
                                     32'hdeadbeef, 32'h87654321, 32'h55AA55AA, 32'hAA55AA55};

    logic          ui_clk = 1'b0;
    logic          rst;
    logic          start;
    logic [1:0]    mode;
    logic [AW-1:0] base_addr;
    logic          calib_done;
    logic [AW-1:0] app_addr;
    logic [2:0]    app_cmd;
    logic          app_en;
    logic [DW-1:0] app_wdf_data;
    logic          app_wdf_wren;
    logic          app_wdf_end;
    logic [DW/8-1:0] app_wdf_mask;
    logic          app_rdy;
    logic          app_wdf_rdy;
    logic [DW-1:0] app_rd_data;
    logic          app_rd_data_valid;
    logic          busy, done, pass, aborted;
    logic [15:0]   err_cnt;
    logic [AW-1:0] first_err_addr;

    always #5 ui_clk = ~ui_clk;

    mig_mem_tester #(.NUM_BEATS(4)) dut (
        .ui_clk(ui_clk), .rst(rst), .start(start), .mode(mode), .base_addr(base_addr),
        .calib_done(calib_done), .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en),
        .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
        .app_wdf_mask(app_wdf_mask), .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy),
        .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid), .busy(busy),
        .done(done), .pass(pass), .aborted(aborted), .err_cnt(err_cnt), .first_err_addr(first_err_addr)
    );

    logic [DW-1:0] mem [logic [AW-1:0]];
    logic [AW-1:0] wa_q[$];
    logic [DW-1:0] wd_q[$];
    logic [AW-1:0] ra_q[$];
    int            rt_q[$];
    logic [AW-1:0] wr_log[$];
    int            cyc = 0, wr_count = 0, rd_cmds = 0, wdf_viol = 0, en_age = 0;
    logic          delay_cmd, flip_en;
    logic [AW-1:0] flip_addr;
    int            rd_lat;
    logic [AW-1:0] ma;
    logic [DW-1:0] md;

    always @(posedge ui_clk or negedge ui_clk) begin
        if (ui_clk) begin
            cyc++;
            if (rst) begin
                wa_q.delete(); wd_q.delete(); ra_q.delete(); rt_q.delete();
            end else begin
                if (app_wdf_end !== app_wdf_wren || app_wdf_mask !== '0) wdf_viol++;
                if (app_en && app_rdy) begin
                    if (app_cmd == 3'b000) begin
                        wa_q.push_back(app_addr);
                    end else begin
                        ra_q.push_back(app_addr);
                        rt_q.push_back(cyc + rd_lat);
                        rd_cmds++;
                    end
                end
                if (app_wdf_wren && app_wdf_rdy) wd_q.push_back(app_wdf_data);
                while (wa_q.size() > 0 && wd_q.size() > 0) begin
                    ma = wa_q.pop_front();
                    mem[ma] = wd_q.pop_front();
                    wr_log.push_back(ma);
                    wr_count++;
                end
            end
        end else begin
            app_rd_data_valid = 1'b0;
            if (ra_q.size() > 0 && cyc >= rt_q[0]) begin
                ma = ra_q.pop_front();
                void'(rt_q.pop_front());
                md = mem.exists(ma) ? mem[ma] : '0;
                if (flip_en && ma == flip_addr) md[0] = ~md[0];
                app_rd_data       = md;
                app_rd_data_valid = 1'b1;
            end
            en_age  = app_en ? en_age + 1 : 0;
            // Delayed mode: data strobe is taken at once, command only after the fourth cycle of app_en.
            app_rdy = !delay_cmd || (en_age >= 4);
        end
    end

    int checks = 0, errors = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] addr_pat(input logic [AW-1:0] a);
        logic [DW-1:0] d;
        for (int k = 0; k < DW/32; k++) d[k*32 +: 32] = {3'b000, a} ^ 32'(k);
        return d;
    endfunction

    task automatic kick(input logic [1:0] m, input logic [AW-1:0] b);
        @(negedge ui_clk);
        mode = m; base_addr = b; start = 1'b1;
        @(negedge ui_clk);
        start = 1'b0;
    endtask

    task automatic run(input string tag, input logic [1:0] m, input logic [AW-1:0] b);
        kick(m, b);
        for (int i = 0; i < 500 && !done; i++) @(negedge ui_clk);
        check(tag, done, 1'b1);
    endtask

    int w0, r0;
    logic [DW-1:0] cd;

    initial begin
        rst = 1'b1; start = 1'b0; mode = 2'd0; base_addr = '0; calib_done = 1'b0;
        app_wdf_rdy = 1'b1; delay_cmd = 1'b0; flip_en = 1'b0; flip_addr = '0; rd_lat = 2;
        repeat (3) @(negedge ui_clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass_abort", {pass, aborted}, 0);
        check("rst_en_wren", {app_en, app_wdf_wren}, 0);
        check("rst_addr_cmd", {app_addr, app_cmd}, 0);
        check("rst_err", {err_cnt, first_err_addr}, 0);
        rst = 1'b0;

        kick(2'd0, '0);
        @(negedge ui_clk);
        check("nocal_start_ignored", busy, 0);
        calib_done = 1'b1;

        w0 = wr_count; r0 = rd_cmds;
        run("m0_done", 2'd0, 29'h0);
        check("m0_pass", pass, 1);
        check("m0_err", err_cnt, 0);
        check("m0_writes", wr_count - w0, 4);
        check("m0_reads", rd_cmds - r0, 4);
        for (int i = 0; i < 4; i++) check("m0_waddr", wr_log[w0 + i], 29'(i * 8));
        check("m0_mem", mem[29'h18], PAT);

        flip_en = 1'b1; flip_addr = 29'h110;
        run("flip_done", 2'd0, 29'h100);
        check("flip_pass", pass, 0);
        check("flip_err", err_cnt, 1);
        check("flip_first", first_err_addr, 29'h110);
        flip_en = 1'b0;

        delay_cmd = 1'b1; w0 = wr_count;
        run("m1_done", 2'd1, 29'h200);
        check("m1_writes", wr_count - w0, 4);
        check("m1_pass", pass, 1);
        for (int i = 0; i < 4; i++) check("m1_mem", mem[29'h200 + 29'(i * 8)], addr_pat(29'h200 + 29'(i * 8)));
        cd = mem[29'h208];
        check("m1_w7", cd[255:224], 32'h0000_020F);
        delay_cmd = 1'b0;

        run("m2_done", 2'd2, 29'h300);
        check("m2_even", mem[29'h300], PAT);
        check("m2_odd", mem[29'h308], ~PAT);
        check("m2_pass", pass, 1);

        run("m3_done", 2'd3, 29'h400);
        check("m3_pass", pass, 1);
        cd = mem[29'h400];
`ifdef MEM_TEST_LFSR_EN
        check("m3_b0w0", cd[31:0], 32'h0000_0001);
        check("m3_b0w1", cd[63:32], 32'h0000_0000);
        cd = mem[29'h408];
        check("m3_b1w0", cd[31:0], 32'h8020_0003);
`else
        check("m3_fixed", cd, PAT);
`endif

        rd_lat = 20; r0 = rd_cmds;
        kick(2'd0, 29'h500);
        for (int i = 0; i < 500 && (rd_cmds - r0) < 4; i++) @(negedge ui_clk);
        check("ab_rdcmds", rd_cmds - r0, 4);
        calib_done = 1'b0;
        @(negedge ui_clk);
        check("ab_en", app_en, 0);
        check("ab_done_abort", {done, aborted}, 2'b11);
        check("ab_pass_busy", {pass, busy}, 0);
        calib_done = 1'b1; rd_lat = 2;
        repeat (40) @(negedge ui_clk);
        check("ab_ignore_late", {err_cnt, done, aborted}, {16'd0, 2'b11});

        delay_cmd = 1'b1;
        kick(2'd0, 29'h600);
        for (int i = 0; i < 100 && !(app_en && !app_wdf_wren && busy); i++) @(negedge ui_clk);
        check("rw_in_wr_wait", {busy, app_en, app_wdf_wren}, 3'b110);
        rst = 1'b1;
        @(negedge ui_clk);
        check("rw_busy_done", {busy, done, pass, aborted}, 0);
        check("rw_en_addr", {app_en, app_wdf_wren, app_addr, app_cmd}, 0);
        rst = 1'b0;
        @(negedge ui_clk);
        run("rw_done", 2'd0, 29'h600);
        check("rw_pass", pass, 1);
        check("rw_err", err_cnt, 0);
        delay_cmd = 1'b0;

        check("wdf_end_mask", wdf_viol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule

// File: doc/mig_mem_tester.md
MIG_MEM_TESTER -- requirements
Module: mig_mem_tester

Interface
REQ-001 SHALL have parameter DATA_W, default 256, app data width in bits (multiple of 32).
REQ-002 SHALL have parameter ADDR_W, default 29, app address width.
REQ-003 SHALL have parameter NUM_BEATS, default 16, beats per test pass (1..65535).
REQ-004 SHALL have parameter ADDR_STEP, default 8, address increment per beat.
REQ-005 SHALL have parameter PATTERN, default {cafebabe,12345678,AA55AA55,55AA55AA,deadbeef,87654321,55AA55AA,AA55AA55}, fixed pattern, DATA_W bits.
REQ-006 SHALL have parameter SEED, default 32'h0000_0001, LFSR seed, nonzero.
REQ-007 Clocking: one clock, ui_clk; reset rst, asynchronous, active-high.
REQ-008 Ports (name dir width meaning): ui_clk in 1 clock; rst in 1 reset; start in 1 start pulse; mode in 2 pattern select; base_addr in ADDR_W first beat address; calib_done in 1 MIG calibration complete.
REQ-009 MIG side: app_addr out ADDR_W; app_cmd out 3; app_en out 1; app_wdf_data out DATA_W; app_wdf_wren out 1; app_wdf_end out 1; app_wdf_mask out DATA_W/8; app_rdy in 1; app_wdf_rdy in 1; app_rd_data in DATA_W; app_rd_data_valid in 1.
REQ-010 Status: busy out 1; done out 1; pass out 1; aborted out 1; err_cnt out 16; first_err_addr out ADDR_W.

Function
REQ-011 FSM states IDLE, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_DRAIN, DONE; start accepted only in IDLE or DONE with calib_done=1, else ignored.
REQ-012 On accepted start: latch mode and base_addr, clear done/pass/aborted/err_cnt/first_err_addr, reset both beat indices and LFSR states to SEED, go WR_ISSUE.
REQ-013 WR_ISSUE: assert app_en and app_wdf_wren together, app_cmd=000, app_addr=base+i*ADDR_STEP, data=pattern(i); go WR_WAIT.
REQ-014 WR_WAIT: drop app_en the cycle after app_en&app_rdy; drop app_wdf_wren the cycle after app_wdf_wren&app_wdf_rdy; acceptances may occur in any order or same cycle; next beat only after both accepted; after beat NUM_BEATS-1 go RD_ISSUE.
REQ-015 app_wdf_end SHALL equal app_wdf_wren; app_wdf_mask SHALL be all zero.
REQ-016 RD_ISSUE: app_cmd=001, hold app_en until app_rdy; on acceptance advance address next cycle without deasserting app_en (back-to-back reads); after NUM_BEATS accepted go RD_DRAIN.
REQ-017 Read responses counted in every state from RD_ISSUE onward; each app_rd_data_valid compared to expected pattern of response index j (in-order); responses beyond NUM_BEATS ignored.
REQ-018 Mismatch: err_cnt increments, saturating at 16'hFFFF; first mismatch captures base+j*ADDR_STEP into first_err_addr.
REQ-019 When response count reaches NUM_BEATS: go DONE, done=1, pass=(err_cnt==0 including current beat), busy=0.
REQ-020 Patterns: mode 0 PATTERN; mode 1 each 32-bit word k = beat address[31:0] XOR k; mode 2 PATTERN for even beats, ~PATTERN for odd beats; mode 3 LFSR (REQ-026).
REQ-021 calib_done falling while busy: deassert app_en/app_wdf_wren next cycle, go DONE, done=1, pass=0, aborted=1.
REQ-022 busy=1 in all states except IDLE and DONE.

Reset
REQ-023 rst asserted: state IDLE immediately; app_en, app_wdf_wren, busy, done, pass, aborted = 0; err_cnt=0; first_err_addr=0; app_addr=0; app_cmd=000.
REQ-024 Reset mid-operation discards outstanding responses; no read data compared until next start.
REQ-025 Data registers (app_wdf_data) need no reset value.

Configuration
REQ-026 Macro MEM_TEST_LFSR_EN defined: mode 3 uses 32-bit Galois LFSR, x^32+x^22+x^2+x+1, advanced once per beat, word k = state XOR k.
REQ-027 MEM_TEST_LFSR_EN undefined: no LFSR logic; mode 3 behaves as mode 0.

Structure
REQ-028 Package mem_test_pkg SHALL hold state encoding, CMD_WRITE=000/CMD_READ=001, mode encodings, LFSR tap constant.
REQ-029 Sub-module mem_test_patgen (beat index/address/LFSR in, DATA_W pattern out) SHALL be instantiated twice: write generator and expected-data generator.

Verification
REQ-030 Mode 0, NUM_BEATS=4, ideal memory model -> 4 writes at base, +8, +16, +24, then 4 reads; done=1, pass=1, err_cnt=0.
REQ-031 Model flips bit 0 of beat 2 read data, base=0x100 -> pass=0, err_cnt=1, first_err_addr=0x110.
REQ-032 app_wdf_rdy accepted 3 cycles before app_rdy on each beat -> no duplicate or lost writes; memory contents match mode 1 pattern.
REQ-033 calib_done dropped during RD_DRAIN -> next cycle app_en=0, done=1, aborted=1, pass=0.
REQ-034 Mode 3 with and without MEM_TEST_LFSR_EN -> defined: beat 0 word 0 = SEED, pass=1; undefined: data equals PATTERN, pass=1.
REQ-035 rst pulsed mid WR_WAIT, then start -> all outputs at reset values, second run completes with pass=1.
